// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the RV32 decode/execute control path.
//   ctrl_t      : control bundle carried from decode into the E register
//   OP_* / F7_* : major opcodes and funct7 values recognised by decode
//   ALU_*, IMM_*, RES_*, BH_* : field encodings of the bundle
//   md_state_e  : state of the multi-cycle MUL/DIV sequencer
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] RES_ALU    = 3'b000;
  localparam logic [2:0] RES_MEM    = 3'b001;
  localparam logic [2:0] RES_PC4    = 3'b010;
  localparam logic [2:0] RES_IMM    = 3'b011;
  localparam logic [2:0] RES_PC_IMM = 3'b100;
  localparam logic [2:0] RES_MD     = 3'b101;

  localparam logic [1:0] BH_WORD = 2'b00;
  localparam logic [1:0] BH_BYTE = 2'b01;
  localparam logic [1:0] BH_HALF = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [2:0] result_src;
    logic       branch;
    logic       jump;
    logic       sign;
    logic [3:0] alu_control;
    logic [1:0] byte_half_op;
    logic       pc_target_src;
    logic [2:0] funct3;
  } ctrl_t;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // ALU op for register/immediate arithmetic; alt selects sub (000) or sra (101).
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_decode.sv
// Purely combinational RV32I(+M) instruction decoder.
//   instr   : 32-bit instruction
//   ctrl    : decoded control bundle (all zero when illegal)
//   illegal : instruction is not recognised / not enabled
// ENABLE_M = 0 turns MUL/DIV/REM encodings into illegal instructions.
module rv_decode
  import riscv_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opcode_s;
  logic [2:0] f3_s;
  logic [6:0] f7_s;
  ctrl_t      ctrl_s;
  logic       illegal_s;
  logic       unused_bits_s;

  assign opcode_s      = instr[6:0];
  assign f3_s          = instr[14:12];
  assign f7_s          = instr[31:25];
  assign unused_bits_s = ^{instr[24:15], instr[11:7]};

  // Opcode/funct decode into the raw bundle and the illegal flag.
  always_comb begin
    ctrl_s    = '0;
    illegal_s = 1'b0;
    case (opcode_s)
      OP_LOAD: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.imm_src    = IMM_I;
        ctrl_s.alu_src    = 1'b1;
        ctrl_s.result_src = RES_MEM;
        ctrl_s.funct3     = f3_s;
        case (f3_s)
          3'b000:  begin ctrl_s.byte_half_op = BH_BYTE; ctrl_s.sign = 1'b1; end
          3'b001:  begin ctrl_s.byte_half_op = BH_HALF; ctrl_s.sign = 1'b1; end
          3'b010:  begin ctrl_s.byte_half_op = BH_WORD; ctrl_s.sign = 1'b1; end
          3'b100:  begin ctrl_s.byte_half_op = BH_BYTE; ctrl_s.sign = 1'b0; end
          3'b101:  begin ctrl_s.byte_half_op = BH_HALF; ctrl_s.sign = 1'b0; end
          default: illegal_s = 1'b1;
        endcase
      end
      OP_STORE: begin
        ctrl_s.imm_src   = IMM_S;
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.mem_write = 1'b1;
        ctrl_s.funct3    = f3_s;
        case (f3_s)
          3'b000:  ctrl_s.byte_half_op = BH_BYTE;
          3'b001:  ctrl_s.byte_half_op = BH_HALF;
          3'b010:  ctrl_s.byte_half_op = BH_WORD;
          default: illegal_s = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        ctrl_s.imm_src     = IMM_B;
        ctrl_s.branch      = 1'b1;
        ctrl_s.alu_control = ALU_SUB;
        ctrl_s.funct3      = f3_s;
      end
      OP_RTYPE: begin
        if ((f7_s == F7_BASE) || (f7_s == F7_ALT)) begin
          ctrl_s.reg_write   = 1'b1;
          ctrl_s.alu_control = alu_from_funct3(f3_s, instr[30]);
          ctrl_s.funct3      = f3_s;
        end else if (ENABLE_M && (f7_s == F7_MULDIV)) begin
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.result_src = RES_MD;
          ctrl_s.funct3     = f3_s;
        end else begin
          illegal_s = 1'b1;
        end
      end
      OP_IALU: begin
        ctrl_s.reg_write   = 1'b1;
        ctrl_s.imm_src     = IMM_I;
        ctrl_s.alu_src     = 1'b1;
        // No subi: bit 30 only matters for the right-shift form.
        ctrl_s.alu_control = alu_from_funct3(f3_s, instr[30] & (f3_s == 3'b101));
        ctrl_s.funct3      = f3_s;
      end
      OP_JAL: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.imm_src    = IMM_J;
        ctrl_s.jump       = 1'b1;
        ctrl_s.result_src = RES_PC4;
      end
      OP_JALR: begin
        ctrl_s.reg_write     = 1'b1;
        ctrl_s.imm_src       = IMM_I;
        ctrl_s.alu_src       = 1'b1;
        ctrl_s.jump          = 1'b1;
        ctrl_s.result_src    = RES_PC4;
        ctrl_s.pc_target_src = 1'b1;
        ctrl_s.funct3        = f3_s;
      end
      OP_LUI: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.imm_src    = IMM_U;
        ctrl_s.result_src = RES_IMM;
      end
      OP_AUIPC: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.imm_src    = IMM_U;
        ctrl_s.result_src = RES_PC_IMM;
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // An illegal instruction must never carry side effects downstream.
  assign ctrl    = illegal_s ? ctrl_t'('0) : ctrl_s;
  assign illegal = illegal_s;

endmodule

// File: rtl/decode_ctrl_stage.sv
// Decode-to-execute control stage: decodes instr_d and captures the control
// bundle into the E pipeline register, with a MUL/DIV occupancy sequencer.
//   clk, reset       : clock, asynchronous active-high reset
//   instr_d, valid_d : D-stage instruction and its valid flag
//   stall_e, flush_e : downstream hold / squash of the E register
//   stall_d          : hold fetch/decode while a long MUL/DIV occupies E
//   valid_e, illegal_e, *E : registered E-stage control outputs
//   md_start         : one-cycle pulse when a valid MUL/DIV first sits in E
module decode_ctrl_stage
  import riscv_ctrl_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        stall_e,
  input  logic        flush_e,
  output logic        stall_d,
  output logic        valid_e,
  output logic        illegal_e,
  output logic        RegWriteE,
  output logic [2:0]  ImmSrcE,
  output logic        ALUSrcE,
  output logic        MemWriteE,
  output logic [2:0]  ResultSrcE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        signE,
  output logic [3:0]  ALUControlE,
  output logic [1:0]  ByteHalfOpE,
  output logic        PCTargetSrcE,
  output logic [2:0]  funct3E,
  output logic        md_start
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] MUL_LAT  = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  ctrl_t          dec_ctrl_s;
  logic           dec_illegal_s;
  ctrl_t          ctrl_e_r;
  logic           valid_e_r;
  logic           illegal_e_r;
  logic           md_start_r;
  logic           stall_d_r;
  md_state_e      state_r, state_nx_s;
  logic [CW-1:0]  cnt_r, cnt_nx_s;
  logic           hold_s, load_s, md_op_s;
  logic [CW-1:0]  lat_s;

  rv_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .instr   (instr_d),
    .ctrl    (dec_ctrl_s),
    .illegal (dec_illegal_s)
  );

  // Load qualification and latency of the instruction about to enter E.
  always_comb begin
    hold_s  = stall_e | stall_d_r;
    load_s  = ~flush_e & ~hold_s;
    md_op_s = valid_d & ~dec_illegal_s & (dec_ctrl_s.result_src == RES_MD);
    // funct3[2] set means DIV/DIVU/REM/REMU.
    lat_s   = dec_ctrl_s.funct3[2] ? DIV_LAT : MUL_LAT;
  end

  // Sequencer next state: counter runs down regardless of stall_e.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      MD_IDLE: begin
        if (load_s && md_op_s && (lat_s > CNT_ONE)) begin
          state_nx_s = MD_BUSY;
          cnt_nx_s   = lat_s - CNT_ONE;
        end else begin
          state_nx_s = MD_IDLE;
          cnt_nx_s   = CNT_ZERO;
        end
      end
      MD_BUSY: begin
        if (flush_e || (cnt_r == CNT_ONE)) begin
          state_nx_s = MD_IDLE;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          state_nx_s = MD_BUSY;
          cnt_nx_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nx_s = MD_IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
  end

  // Sequencer state, counter and registered stall_d.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= MD_IDLE;
      cnt_r     <= CNT_ZERO;
      stall_d_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      stall_d_r <= (state_nx_s == MD_BUSY);
    end
  end

  // E pipeline register: flush beats hold beats load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e_r    <= '0;
      valid_e_r   <= 1'b0;
      illegal_e_r <= 1'b0;
    end else if (flush_e) begin
      ctrl_e_r    <= '0;
      valid_e_r   <= 1'b0;
      illegal_e_r <= 1'b0;
    end else if (!hold_s) begin
      ctrl_e_r    <= valid_d ? dec_ctrl_s : ctrl_t'('0);
      valid_e_r   <= valid_d;
      illegal_e_r <= valid_d & dec_illegal_s;
    end
  end

  // md_start only fires on the load edge, so a held op never re-triggers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_start_r <= 1'b0;
    end else begin
      md_start_r <= load_s & md_op_s;
    end
  end

  assign stall_d      = stall_d_r;
  assign valid_e      = valid_e_r;
  assign illegal_e    = illegal_e_r;
  assign md_start     = md_start_r;
  assign RegWriteE    = ctrl_e_r.reg_write;
  assign ImmSrcE      = ctrl_e_r.imm_src;
  assign ALUSrcE      = ctrl_e_r.alu_src;
  assign MemWriteE    = ctrl_e_r.mem_write;
  assign ResultSrcE   = ctrl_e_r.result_src;
  assign BranchE      = ctrl_e_r.branch;
  assign JumpE        = ctrl_e_r.jump;
  assign signE        = ctrl_e_r.sign;
  assign ALUControlE  = ctrl_e_r.alu_control;
  assign ByteHalfOpE  = ctrl_e_r.byte_half_op;
  assign PCTargetSrcE = ctrl_e_r.pc_target_src;
  assign funct3E      = ctrl_e_r.funct3;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: instance a (M enabled, MUL 1, DIV 4) and
// instance b (M disabled) share stimulus; both are compared every cycle
// against a transaction-level reference model, plus directed scenarios.
module tb_decode_ctrl_stage;

  localparam int MUL_A = 1;
  localparam int DIV_A = 4;
  localparam int MUL_B = 1;
  localparam int DIV_B = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, valid_d, stall_e, flush_e;
  logic [31:0] instr_d;

  logic stall_d_a, valid_e_a, illegal_e_a, RegWriteE_a, ALUSrcE_a, MemWriteE_a;
  logic BranchE_a, JumpE_a, signE_a, PCTargetSrcE_a, md_start_a;
  logic [2:0] ImmSrcE_a, ResultSrcE_a, funct3E_a;
  logic [3:0] ALUControlE_a;
  logic [1:0] ByteHalfOpE_a;
  logic stall_d_b, valid_e_b, illegal_e_b, RegWriteE_b, ALUSrcE_b, MemWriteE_b;
  logic BranchE_b, JumpE_b, signE_b, PCTargetSrcE_b, md_start_b;
  logic [2:0] ImmSrcE_b, ResultSrcE_b, funct3E_b;
  logic [3:0] ALUControlE_b;
  logic [1:0] ByteHalfOpE_b;

  decode_ctrl_stage #(.ENABLE_M(1'b1), .MUL_CYCLES(MUL_A), .DIV_CYCLES(DIV_A)) u_dut_a (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .stall_d(stall_d_a), .valid_e(valid_e_a),
    .illegal_e(illegal_e_a), .RegWriteE(RegWriteE_a), .ImmSrcE(ImmSrcE_a),
    .ALUSrcE(ALUSrcE_a), .MemWriteE(MemWriteE_a), .ResultSrcE(ResultSrcE_a),
    .BranchE(BranchE_a), .JumpE(JumpE_a), .signE(signE_a), .ALUControlE(ALUControlE_a),
    .ByteHalfOpE(ByteHalfOpE_a), .PCTargetSrcE(PCTargetSrcE_a), .funct3E(funct3E_a),
    .md_start(md_start_a)
  );

  decode_ctrl_stage #(.ENABLE_M(1'b0), .MUL_CYCLES(MUL_B), .DIV_CYCLES(DIV_B)) u_dut_b (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .stall_d(stall_d_b), .valid_e(valid_e_b),
    .illegal_e(illegal_e_b), .RegWriteE(RegWriteE_b), .ImmSrcE(ImmSrcE_b),
    .ALUSrcE(ALUSrcE_b), .MemWriteE(MemWriteE_b), .ResultSrcE(ResultSrcE_b),
    .BranchE(BranchE_b), .JumpE(JumpE_b), .signE(signE_b), .ALUControlE(ALUControlE_b),
    .ByteHalfOpE(ByteHalfOpE_b), .PCTargetSrcE(PCTargetSrcE_b), .funct3E(funct3E_b),
    .md_start(md_start_b)
  );

  // Observed bundle: {illegal, regwrite, imm, alusrc, memwrite, result, branch,
  // jump, sign, alu, bytehalf, pctarget, funct3}
  logic [22:0] obs_a, obs_b;
  assign obs_a = {illegal_e_a, RegWriteE_a, ImmSrcE_a, ALUSrcE_a, MemWriteE_a, ResultSrcE_a,
                  BranchE_a, JumpE_a, signE_a, ALUControlE_a, ByteHalfOpE_a, PCTargetSrcE_a, funct3E_a};
  assign obs_b = {illegal_e_b, RegWriteE_b, ImmSrcE_b, ALUSrcE_b, MemWriteE_b, ResultSrcE_b,
                  BranchE_b, JumpE_b, signE_b, ALUControlE_b, ByteHalfOpE_b, PCTargetSrcE_b, funct3E_b};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode written from the instruction-set rules.
  function automatic logic [22:0] ref_decode(input logic [31:0] ins, input bit enm);
    logic [6:0] op, f7;
    logic [2:0] f3, imm, res;
    logic       ill, rw, asrc, mw, br, jmp, sg, pct;
    logic [3:0] alu;
    logic [1:0] bh;
    logic [3:0] alu_tab [8];
    alu_tab = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    {ill, rw, imm, asrc, mw, res, br, jmp, sg, alu, bh, pct} = '0;
    // width mapping for loads/stores: f3[1:0] 0 byte, 1 half, 2 word
    bh = (f3[1:0] == 2'd0) ? 2'd1 : (f3[1:0] == 2'd1) ? 2'd2 : 2'd0;
    case (op)
      7'h03: begin
        if (f3 == 3'd3 || f3 >= 3'd6) ill = 1'b1;
        rw = 1'b1; asrc = 1'b1; res = 3'd1; sg = ~f3[2];
      end
      7'h23: begin
        if (f3 >= 3'd3) ill = 1'b1;
        asrc = 1'b1; mw = 1'b1; imm = 3'd1;
      end
      7'h63: begin imm = 3'd2; br = 1'b1; alu = 4'd1; bh = 2'd0; end
      7'h33: begin
        bh = 2'd0; rw = 1'b1;
        if (f7 == 7'h00 || f7 == 7'h20) begin
          alu = alu_tab[f3];
          if (ins[30] && f3 == 3'd0) alu = 4'd1;
          if (ins[30] && f3 == 3'd5) alu = 4'd9;
        end else if (f7 == 7'h01 && enm) begin
          res = 3'd5;
        end else begin
          ill = 1'b1;
        end
      end
      7'h13: begin
        bh = 2'd0; rw = 1'b1; asrc = 1'b1; alu = alu_tab[f3];
        if (ins[30] && f3 == 3'd5) alu = 4'd9;
      end
      7'h6f: begin bh = 2'd0; rw = 1'b1; imm = 3'd3; jmp = 1'b1; res = 3'd2; f3 = 3'd0; end
      7'h67: begin bh = 2'd0; rw = 1'b1; asrc = 1'b1; jmp = 1'b1; res = 3'd2; pct = 1'b1; end
      7'h37: begin bh = 2'd0; rw = 1'b1; imm = 3'd4; res = 3'd3; f3 = 3'd0; end
      7'h17: begin bh = 2'd0; rw = 1'b1; imm = 3'd4; res = 3'd4; f3 = 3'd0; end
      default: ill = 1'b1;
    endcase
    if (ill) return {1'b1, 22'd0};
    return {1'b0, rw, imm, asrc, mw, res, br, jmp, sg, alu, bh, pct, f3};
  endfunction

  // Transaction-level model state per instance: E contents and remaining stall cycles.
  logic [22:0] m_bundle [2];
  logic        m_valid  [2];
  logic        m_md     [2];
  int          m_busy   [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_bundle[i] = '0; m_valid[i] = 1'b0; m_md[i] = 1'b0; m_busy[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic [22:0] d;
      bit md;
      int lat;
      d   = ref_decode(instr_d, i == 0);
      md  = valid_d && !d[22] && (d[15:13] == 3'd5);
      lat = (i == 0) ? (instr_d[14] ? DIV_A : MUL_A) : (instr_d[14] ? DIV_B : MUL_B);
      if (flush_e) begin
        m_bundle[i] = '0; m_valid[i] = 1'b0; m_md[i] = 1'b0; m_busy[i] = 0;
      end else if (stall_e || m_busy[i] > 0) begin
        m_md[i] = 1'b0;
        if (m_busy[i] > 0) m_busy[i] = m_busy[i] - 1;
      end else begin
        m_valid[i]  = valid_d;
        m_bundle[i] = valid_d ? d : 23'd0;
        m_md[i]     = md;
        m_busy[i]   = md ? lat - 1 : 0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("bundle_a",   32'(obs_a),      32'(m_bundle[0]));
    check_eq("valid_a",    32'(valid_e_a),  32'(m_valid[0]));
    check_eq("stall_d_a",  32'(stall_d_a),  32'(m_busy[0] > 0));
    check_eq("md_start_a", 32'(md_start_a), 32'(m_md[0]));
    check_eq("bundle_b",   32'(obs_b),      32'(m_bundle[1]));
    check_eq("valid_b",    32'(valid_e_b),  32'(m_valid[1]));
    check_eq("stall_d_b",  32'(stall_d_b),  32'(m_busy[1] > 0));
    check_eq("md_start_b", 32'(md_start_b), 32'(m_md[1]));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    instr_d = ins; valid_d = v; stall_e = st; flush_e = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op, f7;
    r = $urandom;
    case ($urandom_range(0, 10))
      0:       op = 7'h03;
      1:       op = 7'h23;
      2:       op = 7'h63;
      3, 4:    op = 7'h33;
      5:       op = 7'h13;
      6:       op = 7'h6f;
      7:       op = 7'h67;
      8:       op = 7'h37;
      9:       op = 7'h17;
      default: op = r[6:0];
    endcase
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], op};
  endfunction

  localparam logic [31:0] I_LW  = 32'h00012083;
  localparam logic [31:0] I_DIV = 32'h025241B3;
  localparam logic [31:0] I_MUL = 32'h025201B3;
  localparam logic [31:0] I_ADD = 32'h005201B3;
  localparam logic [31:0] I_SW  = 32'h0020A023;

  initial begin
    reset = 1'b1;
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    reset = 1'b0;

    // lw decode
    drive(I_LW, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("lw_valid",  32'(valid_e_a),     32'd1);
    check_eq("lw_rw",     32'(RegWriteE_a),   32'd1);
    check_eq("lw_imm",    32'(ImmSrcE_a),     32'd0);
    check_eq("lw_alusrc", 32'(ALUSrcE_a),     32'd1);
    check_eq("lw_res",    32'(ResultSrcE_a),  32'd1);
    check_eq("lw_bh",     32'(ByteHalfOpE_a), 32'd0);
    check_eq("lw_sign",   32'(signE_a),       32'd1);
    check_eq("lw_alu",    32'(ALUControlE_a), 32'd0);
    check_eq("lw_stall",  32'(stall_d_a),     32'd0);

    // div occupies E for 4 cycles, stall_d for 3
    drive(I_DIV, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("div_res",   32'(ResultSrcE_a), 32'd5);
    check_eq("div_f3",    32'(funct3E_a),    32'd4);
    check_eq("div_start", 32'(md_start_a),   32'd1);
    check_eq("div_stall", 32'(stall_d_a),    32'd1);
    drive(I_ADD, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check_eq("div_start_once", 32'(md_start_a),   32'd0);
      check_eq("div_resident",   32'(ResultSrcE_a), 32'd5);
      check_eq("div_stall_len",  32'(stall_d_a),    32'(k < 3));
    end
    step();
    check_eq("div_next_res", 32'(ResultSrcE_a), 32'd0);
    check_eq("div_next_rw",  32'(RegWriteE_a),  32'd1);

    // mul: illegal without M, single-cycle with M
    drive(I_MUL, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("nom_illegal", 32'(illegal_e_b), 32'd1);
    check_eq("nom_rw",      32'(RegWriteE_b), 32'd0);
    check_eq("nom_mw",      32'(MemWriteE_b), 32'd0);
    check_eq("nom_stall",   32'(stall_d_b),   32'd0);
    check_eq("nom_start",   32'(md_start_b),  32'd0);
    check_eq("mul1_start",  32'(md_start_a),  32'd1);
    check_eq("mul1_stall",  32'(stall_d_a),   32'd0);
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("bubble_valid", 32'(valid_e_a), 32'd0);

    // flush while BUSY
    drive(I_DIV, 1'b1, 1'b0, 1'b0);
    step();
    drive(I_ADD, 1'b1, 1'b0, 1'b0);
    step();
    drive(I_ADD, 1'b1, 1'b0, 1'b1);
    step();
    check_eq("flush_valid", 32'(valid_e_a), 32'd0);
    check_eq("flush_stall", 32'(stall_d_a), 32'd0);
    drive(I_ADD, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("post_flush_valid", 32'(valid_e_a),    32'd1);
    check_eq("post_flush_res",   32'(ResultSrcE_a), 32'd0);

    // stall_e holding a store, then flush+stall together
    drive(I_SW, 1'b1, 1'b0, 1'b0);
    step();
    drive(I_ADD, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("sw_hold_mw",  32'(MemWriteE_a), 32'd1);
      check_eq("sw_hold_imm", 32'(ImmSrcE_a),   32'd1);
    end
    drive(I_ADD, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("sw_release_mw", 32'(MemWriteE_a), 32'd0);
    check_eq("sw_release_rw", 32'(RegWriteE_a), 32'd1);
    drive(I_ADD, 1'b1, 1'b1, 1'b1);
    step();
    check_eq("flush_stall_valid", 32'(valid_e_a), 32'd0);
    check_eq("flush_stall_bundle", 32'(obs_a), 32'd0);

    // asynchronous reset mid-BUSY
    drive(I_DIV, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'd0, 1'b0, 1'b0, 1'b0);
    step();
    #2 reset = 1'b1;
    #1;
    check_eq("arst_bundle_a", 32'(obs_a),      32'd0);
    check_eq("arst_valid_a",  32'(valid_e_a),  32'd0);
    check_eq("arst_stall_a",  32'(stall_d_a),  32'd0);
    check_eq("arst_start_a",  32'(md_start_a), 32'd0);
    check_eq("arst_bundle_b", 32'(obs_b),      32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(I_LW, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("arst_lw_valid", 32'(valid_e_a),    32'd1);
    check_eq("arst_lw_res",   32'(ResultSrcE_a), 32'd1);

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      drive(rand_instr(), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
Registered decode-to-execute control stage for the pipelined RV32 core. It decodes the D-stage instruction into the control bundle and captures it into the E-stage pipeline register. Over the existing RV32I decode it adds:
- optional M-extension decode;
- illegal-instruction detection;
- stall/flush handling;
- a multi-cycle MUL/DIV sequencer that stalls decode while a long operation occupies E.

Parameters:
- ENABLE_M, 1, 1 decodes MUL/DIV/REM (op 0110011, funct7 0000001); 0 flags them illegal.
- MUL_CYCLES, 1, E-stage residency in cycles for MUL/MULH/MULHSU/MULHU (>=1).
- DIV_CYCLES, 32, E-stage residency in cycles for DIV/DIVU/REM/REMU (>=1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instr_d  in  32  D-stage instruction
- valid_d  in  1  instr_d is a real instruction (0 = bubble)
- stall_e  in  1  downstream hold; E register keeps its contents
- flush_e  in  1  squash: E register becomes a bubble
- stall_d  out  1  hold fetch/decode; high while sequencer busy
- valid_e  out  1  E register holds a real instruction
- illegal_e  out  1  E instruction illegal (trap request)
- RegWriteE  out  1
- ImmSrcE  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUSrcE  out  1
- MemWriteE  out  1
- ResultSrcE  out  3  000 ALU, 001 mem, 010 PC+4, 011 imm, 100 PC+imm, 101 mul/div unit
- BranchE  out  1
- JumpE  out  1
- signE  out  1  0 unsigned, 1 signed load
- ALUControlE  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra
- ByteHalfOpE  out  2  00 word, 01 byte, 10 half
- PCTargetSrcE  out  1  1 for jalr
- funct3E  out  3  branch condition / mul-div op select
- md_start  out  1  one-cycle pulse: mul/div operands valid in E, start unit

Behaviour:
- Reset: all outputs 0, FSM IDLE, counter 0. The asynchronous reset overrides any operation in progress.
- Combinational decode rules:
  - Loads, stores, branch, R-type, I-ALU, jal, lui, auipc and jalr decode to the standard bundle.
  - Branch uses sub.
  - I-ALU subi does not exist: funct7_5 selects sra only for funct3 101.
  - R-type funct7 other than 0000000/0100000 (and 0000001 when ENABLE_M) is illegal.
  - Unknown opcodes are illegal.
  - Load funct3 011/110/111 and store funct3 >= 011 are illegal.
  - Illegal instruction gives an all-zero bundle with illegal=1.
  - M op gives RegWrite=1, ResultSrc=101, ALUSrc=0.
- E register update priority, per edge: flush_e > hold > load. hold = stall_e | stall_d.
  - flush_e: valid_e=0, illegal_e=0, bundle all 0.
  - hold: all E outputs keep their values.
  - load: E takes the decoded bundle.
  - valid_d=0 loads a bubble (bundle 0, illegal 0).
- md_start = 1 for exactly the first cycle a valid M op sits in E. It is not re-asserted while held by stall_e.
- FSM IDLE/BUSY, counter width $clog2(max(MUL_CYCLES, DIV_CYCLES))+1:
  - IDLE to BUSY on a load of a valid M op with latency L>1. Counter = L-1.
  - BUSY: stall_d=1. The counter decrements every cycle, regardless of stall_e. At the edge where counter==1, go to IDLE and counter becomes 0.
  - A stall_d is therefore L-1 cycles long, and the op resides in E for exactly L cycles (absent stall_e).
  - With L==1 no BUSY state is entered.
- flush_e in BUSY: go to IDLE, counter 0, and stall_d drops next cycle.
- stall_d is a registered-state output, with no combinational path from instr_d.

Decomposition:
- Package riscv_ctrl_pkg contains:
  - ctrl_t packed struct (bundle fields above);
  - opcode localparams;
  - ALU, ImmSrc and ResultSrc encodings;
  - md_state_e enum.
- Sub-module rv_decode: purely combinational instr → ctrl_t + illegal, parametrised by ENABLE_M.
- Top block holds the E register, FSM and counter.

Test Plan:
- lw x1,0(x2) = 0x00012083, valid_d=1 → after 1 edge:
  - valid_e=1, RegWriteE=1, ImmSrcE=000, ALUSrcE=1, ResultSrcE=001;
  - ByteHalfOpE=00, signE=1, ALUControlE=0000, stall_d=0.
- div x3,x4,x5 = 0x025241B3, DIV_CYCLES=4 → E loaded with ResultSrcE=101, funct3E=100, md_start=1 for 1 cycle; stall_d=1 for 3 cycles; next instruction enters E on the 4th edge after load.
- ENABLE_M=0, mul 0x025201B3 → illegal_e=1, RegWriteE=0, MemWriteE=0, stall_d never asserted, md_start=0.
- div in BUSY with flush_e pulsed on cycle 2 → next cycle valid_e=0, stall_d=0, FSM IDLE; subsequent add loads normally.
- stall_e=1 held 3 cycles with sw = 0x0020A023 in E → all E outputs unchanged (MemWriteE=1, ImmSrcE=001); on release the next instruction loads. flush_e and stall_e together → bubble.
- reset asserted asynchronously mid-BUSY (between clock edges) → all outputs 0 immediately; after release, first valid instruction loads normally.
